// File: rtl/io_reg_pkg.sv
// io_reg_pkg: shared types and helpers for the IO_REG scheduler slice.
//   sched_state_e : scheduler FSM states
//   IO_REG_OUT_W  : width of the IO_REG output-cell bus (OQI)
//   IO_REG_IN_W   : width of the IO_REG input-cell bus (IQZ)
//   rr_pick()     : round-robin scan of up to MAX_REQ request bits
package io_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    HOLD,
    SAMPLE,
    RESP
  } sched_state_e;

  localparam int IO_REG_OUT_W = 18;
  localparam int IO_REG_IN_W  = 8;
  localparam int MAX_REQ      = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid[0..nreq-1], scanning upward from ptr and wrapping
  // at nreq (not at the next power of two).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 nreq);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (k < nreq && !r.found && valid[idx]) begin
        r.found = 1'b1;
        r.idx   = 3'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/io_reg_sched_if.sv
// io_reg_sched_if: client-side bundle of the IO_REG scheduler.
//   req_valid/req_ready : one bit per requester. A request is accepted in the
//                         cycle where req_valid[i] && req_ready[i] are both
//                         high at the rising clock edge; req_ready is a
//                         one-hot pulse and is never high unless the scheduler
//                         is idle. req_valid may drop at any time before that
//                         edge with no effect.
//   req_data/req_rd/req_hold : per-requester payload, sampled at acceptance.
//   rsp_valid/rsp_data  : one-hot, single-cycle response strobe carrying the
//                         captured IQZ sample (read requests only).
// Modports: master = requesters, slave = scheduler.
interface io_reg_sched_if
  import io_reg_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int OUT_W  = IO_REG_OUT_W,
  parameter int IN_W   = IO_REG_IN_W,
  parameter int HOLD_W = 4
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OUT_W-1:0]  req_data;
  logic [NREQ-1:0]        req_rd;
  logic [NREQ*HOLD_W-1:0] req_hold;
  logic [NREQ-1:0]        rsp_valid;
  logic [IN_W-1:0]        rsp_data;

  modport master (
    output req_valid, req_data, req_rd, req_hold,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_rd, req_hold,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/io_reg_rr_arb.sv
// io_reg_rr_arb: combinational round-robin pick among NREQ request bits.
//   valid : request bits
//   ptr   : requester checked first
//   found : at least one request is pending
//   grant : index of the chosen requester
// Build option IO_REG_SCHED_PRIO_EN: requester 0 wins whenever it is valid.
module io_reg_rr_arb
  import io_reg_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] grant
);
  logic [MAX_REQ-1:0] valid_pad;
  logic [2:0]         ptr_pad;
  rr_pick_t           pick;
  logic               unused_pick;

  always_comb begin
    valid_pad             = '0;
    valid_pad[NREQ-1:0]   = valid;
    ptr_pad               = '0;
    ptr_pad[ID_W-1:0]     = ptr;
    pick                  = rr_pick(valid_pad, ptr_pad, NREQ);
    found                 = pick.found;
    grant                 = pick.idx[ID_W-1:0];
`ifdef IO_REG_SCHED_PRIO_EN
    if (valid[0]) begin
      found = 1'b1;
      grant = '0;
    end
`endif
  end

  // Upper index bits are zero for small NREQ.
  assign unused_pick = ^pick;

endmodule

// File: rtl/io_reg_sched.sv
// io_reg_sched: round-robin scheduler sharing one IO_REG tile among NREQ
// requesters. A granted word is driven on OQI for 1+hold cycles; read
// requests additionally capture IQZ one cycle later and return it on
// rsp_data with a one-cycle rsp_valid strobe to the same requester.
// Ports:
//   IQC, QRT    : clock (rising edge), asynchronous active-low reset
//   req_if      : client bundle (io_reg_sched_if.slave)
//   OQI, oqi_en : output-cell word and its drive qualifier
//   IQZ         : input-cell sample bus
//   grant_id    : index of the current owner
//   busy        : FSM is not in IDLE
//   dbg_state   : FSM state, for observation
// Build option IO_REG_SCHED_PRIO_EN: requester 0 has absolute priority and
// grants to it do not move the round-robin pointer.
module io_reg_sched
  import io_reg_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int OUT_W  = IO_REG_OUT_W,
  parameter  int IN_W   = IO_REG_IN_W,
  parameter  int HOLD_W = 4,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                IQC,
  input  logic                QRT,
  io_reg_sched_if.slave       req_if,
  output logic [OUT_W-1:0]    OQI,
  output logic                oqi_en,
  input  logic [IN_W-1:0]     IQZ,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output sched_state_e        dbg_state
);
  sched_state_e      state;
  logic [ID_W-1:0]   ptr;
  logic              rd_q;
  logic [HOLD_W-1:0] cnt;
  logic              arb_found;
  logic [ID_W-1:0]   arb_grant;
  logic              drive_last;
  logic [NREQ-1:0]   owner_oh;

  io_reg_rr_arb #(.NREQ(NREQ)) u_arb (
    .valid (req_if.req_valid),
    .ptr   (ptr),
    .found (arb_found),
    .grant (arb_grant)
  );

  assign dbg_state = state;
  assign owner_oh  = NREQ'(1) << grant_id;

  // cnt holds the hold count from acceptance; DRIVE is the first drive cycle
  // and each HOLD cycle consumes one count, so the last drive cycle is DRIVE
  // with hold==0 or HOLD with one count left.
  assign drive_last = (state == DRIVE && cnt == '0) ||
                      (state == HOLD  && cnt == HOLD_W'(1));

  // Gated by QRT so no accept pulse is shown while reset is asserted.
  assign req_if.req_ready = (QRT && state == IDLE && arb_found) ?
                            (NREQ'(1) << arb_grant) : '0;

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      state            <= IDLE;
      OQI              <= '0;
      oqi_en           <= 1'b0;
      req_if.rsp_valid <= '0;
      req_if.rsp_data  <= '0;
      grant_id         <= '0;
      busy             <= 1'b0;
      ptr              <= '0;
      rd_q             <= 1'b0;
      cnt              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            OQI      <= req_if.req_data[arb_grant*OUT_W +: OUT_W];
            rd_q     <= req_if.req_rd[arb_grant];
            cnt      <= req_if.req_hold[arb_grant*HOLD_W +: HOLD_W];
            grant_id <= arb_grant;
            oqi_en   <= 1'b1;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE, HOLD: begin
          if (drive_last) begin
            if (rd_q) begin
              state <= SAMPLE;
            end else begin
              oqi_en <= 1'b0;
              state  <= RESP;
            end
          end else begin
            if (state == HOLD) cnt <= cnt - 1'b1;
            state <= HOLD;
          end
        end
        SAMPLE: begin
          req_if.rsp_data  <= IQZ;
          req_if.rsp_valid <= owner_oh;
          oqi_en           <= 1'b0;
          state            <= RESP;
        end
        RESP: begin
          // OQI keeps the last word; only the qualifier drops.
          req_if.rsp_valid <= '0;
          busy             <= 1'b0;
`ifdef IO_REG_SCHED_PRIO_EN
          if (grant_id != '0)
            ptr <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
`else
          ptr <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_reg_sched.sv
// tb_io_reg_sched: bench for io_reg_sched (NREQ=4 main instance plus an
// NREQ=3 instance for non-power-of-two wrap).
module tb_io_reg_sched;
  import io_reg_pkg::*;

  localparam int NREQ = 4, OUT_W = 18, IN_W = 8, HOLD_W = 4, ID_W = 2;
  localparam int NREQ3 = 3, ID3_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  io_reg_sched_if #(.NREQ(NREQ), .OUT_W(OUT_W), .IN_W(IN_W), .HOLD_W(HOLD_W)) bus ();
  io_reg_sched_if #(.NREQ(NREQ3), .OUT_W(OUT_W), .IN_W(IN_W), .HOLD_W(HOLD_W)) bus3 ();

  logic [OUT_W-1:0] oqi, oqi3;
  logic             oqi_en, oqi_en3;
  logic [IN_W-1:0]  iqz;
  logic [ID_W-1:0]  grant_id;
  logic [ID3_W-1:0] grant_id3;
  logic             busy, busy3;
  sched_state_e     dbg_state, dbg_state3;

  io_reg_sched #(.NREQ(NREQ), .OUT_W(OUT_W), .IN_W(IN_W), .HOLD_W(HOLD_W)) u_dut (
    .IQC(clk), .QRT(rst_n), .req_if(bus.slave), .OQI(oqi), .oqi_en(oqi_en),
    .IQZ(iqz), .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  io_reg_sched #(.NREQ(NREQ3), .OUT_W(OUT_W), .IN_W(IN_W), .HOLD_W(HOLD_W)) u_dut3 (
    .IQC(clk), .QRT(rst_n), .req_if(bus3.slave), .OQI(oqi3), .oqi_en(oqi_en3),
    .IQZ(iqz), .grant_id(grant_id3), .busy(busy3), .dbg_state(dbg_state3)
  );

  // ---------------- reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;
  int m_ptr3 = 0;
  int fixed_iqz = -1;

  logic [OUT_W-1:0]  data_a [NREQ];
  logic [HOLD_W-1:0] hold_a [NREQ];
  logic              rd_a   [NREQ];
  logic [IN_W-1:0]   exp_q [$];

  function automatic int model_pick(input logic [7:0] mask, input int ptr, input int n);
`ifdef IO_REG_SCHED_PRIO_EN
    if (mask[0]) return 0;
`endif
    for (int k = 0; k < n; k++)
      if (mask[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic int model_next_ptr(input int g, input int ptr, input int n);
`ifdef IO_REG_SCHED_PRIO_EN
    if (g == 0) return ptr;
`endif
    return (g + 1) % n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*OUT_W +: OUT_W]   = data_a[i];
      bus.req_hold[i*HOLD_W +: HOLD_W] = hold_a[i];
      bus.req_rd[i]                    = rd_a[i];
    end
  endtask

  task automatic scramble_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*OUT_W +: OUT_W]   = OUT_W'($urandom);
      bus.req_hold[i*HOLD_W +: HOLD_W] = HOLD_W'($urandom);
      bus.req_rd[i]                    = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus3.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_ptr3 = 0;
  endtask

  // One full transaction on the NREQ=4 instance, checked cycle by cycle.
  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] busy_mask,
                         input bit hold_valid);
    int g, h;
    logic r;
    logic [OUT_W-1:0] d;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    load_bus();
    bus.req_valid = mask;
    iqz = IN_W'($urandom);
    #1;
    g = model_pick({4'b0, mask}, m_ptr, NREQ);
    if (g < 0) begin
      n_cmp++; n_err++;
      $display("FAIL txn_setup empty mask");
      return;
    end
    d = data_a[g]; h = int'(hold_a[g]); r = rd_a[g];
    oh = '0; oh[g] = 1'b1;
    n_cmp++;
    if (bus.req_ready !== oh || busy !== 1'b0) begin
      n_err++;
      $display("FAIL accept ready=%b exp=%b busy=%b exp=0", bus.req_ready, oh, busy);
    end
    for (int c = 0; c <= h; c++) begin
      @(negedge clk);
      bus.req_valid = hold_valid ? mask : busy_mask;
      scramble_bus();
      iqz = IN_W'($urandom);
      #1;
      n_cmp++;
      if (oqi !== d || oqi_en !== 1'b1 || grant_id !== ID_W'(g) || busy !== 1'b1 ||
          bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
        n_err++;
        $display("FAIL drive c=%0d oqi=%h exp=%h en=%b gid=%0d exp=%0d busy=%b ready=%b rsp=%b",
                 c, oqi, d, oqi_en, grant_id, g, busy, bus.req_ready, bus.rsp_valid);
      end
    end
    if (r) begin
      @(negedge clk);
      bus.req_valid = hold_valid ? mask : busy_mask;
      iqz = (fixed_iqz >= 0) ? IN_W'(fixed_iqz) : IN_W'($urandom);
      exp_q.push_back(iqz);
      #1;
      n_cmp++;
      if (oqi !== d || oqi_en !== 1'b1 || bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
        n_err++;
        $display("FAIL sample oqi=%h exp=%h en=%b exp=1 rsp=%b ready=%b",
                 oqi, d, oqi_en, bus.rsp_valid, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.req_valid = hold_valid ? mask : '0;
    iqz = IN_W'($urandom);
    #1;
    n_cmp++;
    if (oqi !== d || oqi_en !== 1'b0 || busy !== 1'b1 || bus.req_ready !== '0 ||
        bus.rsp_valid !== (r ? oh : '0)) begin
      n_err++;
      $display("FAIL resp oqi=%h exp=%h en=%b exp=0 busy=%b rsp=%b exp=%b",
               oqi, d, oqi_en, busy, bus.rsp_valid, r ? oh : '0);
    end
    if (r) begin
      logic [IN_W-1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.rsp_data !== e) begin
        n_err++;
        $display("FAIL rsp_data got=%h exp=%h", bus.rsp_data, e);
      end
    end
    m_ptr = model_next_ptr(g, m_ptr, NREQ);
  endtask

  // Zero-hold write on the NREQ=3 instance.
  task automatic txn3(input logic [NREQ3-1:0] mask);
    int g;
    logic [NREQ3-1:0] oh;
    @(negedge clk);
    bus3.req_valid = mask;
    #1;
    g = model_pick({5'b0, mask}, m_ptr3, NREQ3);
    oh = '0; oh[g] = 1'b1;
    n_cmp++;
    if (bus3.req_ready !== oh) begin
      n_err++;
      $display("FAIL wrap3_accept ready=%b exp=%b", bus3.req_ready, oh);
    end
    @(negedge clk);
    bus3.req_valid = '0;
    #1;
    n_cmp++;
    if (grant_id3 !== ID3_W'(g) || oqi_en3 !== 1'b1 || oqi3 !== OUT_W'(g + 18'h100)) begin
      n_err++;
      $display("FAIL wrap3_drive gid=%0d exp=%0d en=%b oqi=%h", grant_id3, g, oqi_en3, oqi3);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (oqi_en3 !== 1'b0 || busy3 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap3_resp en=%b exp=0 busy=%b exp=1", oqi_en3, busy3);
    end
    m_ptr3 = model_next_ptr(g, m_ptr3, NREQ3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = '1;
    #2;
    n_cmp++;
    if (oqi !== '0 || oqi_en !== 1'b0 || bus.req_ready !== '0 || bus.rsp_valid !== '0 ||
        bus.rsp_data !== '0 || grant_id !== '0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset oqi=%h en=%b ready=%b rsp=%b rdata=%h gid=%0d busy=%b",
               oqi, oqi_en, bus.req_ready, bus.rsp_valid, bus.rsp_data, grant_id, busy);
    end
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    data_a[0] = 18'h2A5A5; hold_a[0] = 4'd2; rd_a[0] = 1'b0;
    run_txn(4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || oqi_en !== 1'b0 || oqi !== 18'h2A5A5) begin
      n_err++;
      $display("FAIL single_idle busy=%b en=%b oqi=%h exp=2a5a5", busy, oqi_en, oqi);
    end
  endtask

  task automatic test_read_back();
    data_a[2] = OUT_W'($urandom); hold_a[2] = 4'd0; rd_a[2] = 1'b1;
    fixed_iqz = 8'hC3;
    run_txn(4'b0100, 4'b0000, 1'b0);
    fixed_iqz = -1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      data_a[i] = OUT_W'($urandom); hold_a[i] = '0; rd_a[i] = 1'b0;
    end
    repeat (5) run_txn(4'b1111, 4'b0000, 1'b1);
    bus.req_valid = '0;
  endtask

  task automatic test_back_to_back_random();
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        data_a[i] = OUT_W'($urandom);
        hold_a[i] = ($urandom_range(0, 7) == 0) ? 4'hF : HOLD_W'($urandom_range(0, 3));
        rd_a[i]   = 1'($urandom);
      end
      run_txn(NREQ'($urandom_range(1, 15)), NREQ'($urandom), 1'($urandom));
    end
    bus.req_valid = '0;
  endtask

  task automatic test_withdraw();
    logic [OUT_W-1:0] last;
    do_reset();
    data_a[0] = OUT_W'($urandom); hold_a[0] = 4'd1; rd_a[0] = 1'b0;
    last = data_a[0];
    // requester 1 raises valid only while the tile is busy, then drops it
    run_txn(4'b0001, 4'b0010, 1'b0);
    repeat (4) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.req_ready !== '0 || oqi_en !== 1'b0 || busy !== 1'b0 || oqi !== last ||
          grant_id !== '0) begin
        n_err++;
        $display("FAIL withdraw ready=%b en=%b busy=%b oqi=%h exp=%h gid=%0d",
                 bus.req_ready, oqi_en, busy, oqi, last, grant_id);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_a[2] = OUT_W'($urandom); hold_a[2] = 4'd0; rd_a[2] = 1'b0;
    run_txn(4'b0100, 4'b0000, 1'b0);       // pointer now at 3
    data_a[1] = OUT_W'($urandom); hold_a[1] = 4'd5; rd_a[1] = 1'b1;
    @(negedge clk);
    load_bus();
    bus.req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_accept ready=%b exp=0010", bus.req_ready);
    end
    repeat (3) @(negedge clk);              // third drive cycle
    bus.req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (oqi !== '0 || oqi_en !== 1'b0 || busy !== 1'b0 || grant_id !== '0 ||
        bus.rsp_valid !== '0 || bus.rsp_data !== '0 || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL mid_reset oqi=%h en=%b busy=%b gid=%0d rsp=%b rdata=%h",
               oqi, oqi_en, busy, grant_id, bus.rsp_valid, bus.rsp_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.rsp_valid !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL mid_quiet rsp=%b busy=%b", bus.rsp_valid, busy);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      data_a[i] = OUT_W'($urandom); hold_a[i] = '0; rd_a[i] = 1'b1;
    end
    run_txn(4'b1111, 4'b0000, 1'b0);       // must restart from requester 0
  endtask

  task automatic test_wrap3();
    do_reset();
    for (int i = 0; i < NREQ3; i++) bus3.req_data[i*OUT_W +: OUT_W] = OUT_W'(i + 18'h100);
    bus3.req_hold = '0;
    bus3.req_rd   = '0;
    txn3(3'b010);   // pointer -> 2
    txn3(3'b011);   // scan 2, wrap to 0
    txn3(3'b100);   // pointer -> 0 (wraps at 3)
    txn3(3'b111);
    txn3(3'b110);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_rd = '0; bus.req_hold = '0;
    bus3.req_valid = '0; bus3.req_data = '0; bus3.req_rd = '0; bus3.req_hold = '0;
    iqz = '0;
    for (int i = 0; i < NREQ; i++) begin
      data_a[i] = '0; hold_a[i] = '0; rd_a[i] = 1'b0;
    end
    test_reset();
    test_single_write();
    test_read_back();
    test_round_robin();
    test_back_to_back_random();
    test_withdraw();
    test_reset_mid();
    test_wrap3();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
